// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG master: walks the TAP from Run-Test/Idle through a reset, IR/DR scan
// or idle clocks and back, driving tck/tms/tdi and capturing tdo into one response per command.
module jtag_scan_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 6,
  parameter int unsigned TCK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  tck,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo
);

  localparam int unsigned DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RST, S_PATH, S_SHIFT, S_EXIT, S_RUN, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, len_clamp, len_last, path_last;
  logic [DATA_WIDTH-1:0] data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d, data_sh;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                  rsp_valid_q, rsp_valid_d, cmd_ready_q, cmd_ready_d;
  logic                  phase_end;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

  // Effective scan/idle length: 0 means 1, anything above DATA_WIDTH saturates
  always_comb begin
    if (cmd_len == '0)
      len_clamp = LEN_WIDTH'(1);
    else if (cmd_len > LEN_WIDTH'(DATA_WIDTH))
      len_clamp = LEN_WIDTH'(DATA_WIDTH);
    else
      len_clamp = cmd_len;
  end

  assign len_last  = len_q - LEN_WIDTH'(1);
  assign path_last = (op_q == 2'd1) ? LEN_WIDTH'(3) : LEN_WIDTH'(2);
  assign phase_end = (div_q == DIV_W'(TCK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    cap_d       = cap_q;
    div_d       = div_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    data_sh     = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          len_d   = len_clamp;
          data_d  = cmd_data;
          cap_d   = '0;
          cnt_d   = '0;
          div_d   = DIV_W'(TCK_DIV - 1);
          state_d = S_START;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        if (!phase_end) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!tck_q && state_q != S_START) begin
            // Rising tck: the TAP samples tms/tdi, we sample tdo
            tck_d = 1'b1;
            if (state_q == S_SHIFT)
              cap_d = cap_q | (DATA_WIDTH'(tdo) << cnt_q);
          end else begin
            // Start of a low phase: pick the next TCK's tms/tdi or finish
            tck_d = 1'b0;
            case (state_q)
              S_START: begin
                cnt_d = '0;
                tdi_d = 1'b0;
                case (op_q)
                  2'd0:    begin state_d = S_RST;  tms_d = 1'b1; end
                  2'd3:    begin state_d = S_RUN;  tms_d = 1'b0; end
                  default: begin state_d = S_PATH; tms_d = 1'b1; end
                endcase
              end
              S_RST: begin
                if (cnt_q != LEN_WIDTH'(5)) begin
                  cnt_d = cnt_q + LEN_WIDTH'(1);
                  tms_d = (cnt_q != LEN_WIDTH'(4));
                end else begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = cap_q;
                end
              end
              S_PATH: begin
                if (cnt_q != path_last) begin
                  cnt_d = cnt_q + LEN_WIDTH'(1);
                  tms_d = (op_q == 2'd1) && (cnt_q == '0);
                end else begin
                  state_d = S_SHIFT;
                  cnt_d   = '0;
                  tms_d   = (len_q == LEN_WIDTH'(1));
                  tdi_d   = data_q[0];
                end
              end
              S_SHIFT: begin
                if (cnt_q != len_last) begin
                  cnt_d   = cnt_q + LEN_WIDTH'(1);
                  tms_d   = (cnt_d == len_last);
                  data_sh = data_q >> cnt_d;
                  tdi_d   = data_sh[0];
                end else begin
                  state_d = S_EXIT;
                  cnt_d   = '0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
                end
              end
              S_EXIT: begin
                if (cnt_q == '0) begin
                  cnt_d = LEN_WIDTH'(1);
                  tms_d = 1'b0;
                end else begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = cap_q;
                end
              end
              S_RUN: begin
                if (cnt_q != len_last) begin
                  cnt_d = cnt_q + LEN_WIDTH'(1);
                  tms_d = 1'b0;
                end else begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = cap_q;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase

    // Ready only in a settled IDLE, so it rises the clk after a response handshake
    cmd_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE) && !rsp_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

endmodule
